// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA1 Wishbone peripheral: register map, response
// codes, OPS bit positions, error encoding and master state types.
package sha1_pkg;

    localparam logic [31:0] REG_ID_OFF   = 32'h0000_0004;
    localparam logic [31:0] REG_CTRL_OFF = 32'h0000_0008;
    localparam logic [31:0] REG_MSG_OFF  = 32'h0000_000C;
    localparam logic [31:0] REG_DIG_OFF  = 32'h0000_0010;

    localparam logic [31:0] CTRL_ID = 32'h5348_4131;
    localparam logic [31:0] ACK     = 32'h0000_0001;
    localparam logic [31:0] EINVAL  = 32'hffff_ffea;
    localparam logic [31:0] EBUSY   = 32'hffff_fff0;

    localparam int unsigned OPS_RESET_BIT = 1;
    localparam int unsigned OPS_DONE_BIT  = 3;

    typedef enum logic [1:0] {
        ERR_OK   = 2'd0,
        ERR_ID   = 2'd1,
        ERR_BUS  = 2'd2,
        ERR_POLL = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_WR_RST,
        ST_WR_MSG,
        ST_POLL,
        ST_WAIT,
        ST_RD_DIG,
        ST_FIN
    } mst_state_e;

    typedef enum logic [1:0] {
        X_IDLE,
        X_ACTIVE,
        X_GAP
    } xfer_state_e;

    function automatic logic [31:0] ops_mask(input int unsigned b);
        return 32'd1 << b;
    endfunction

endpackage

// File: rtl/sha1_wbm_xfer.sv
// Single Wishbone classic transaction: holds cyc/stb until ack or timeout,
// then inserts one idle cycle before it accepts the next request.
module sha1_wbm_xfer
    import sha1_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] rdata_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    xfer_state_e   state_q;
    logic [TW-1:0] cnt_q;
    logic          cyc_q, stb_q, we_q, done_q, timeout_q;
    logic [3:0]    sel_q;
    logic [31:0]   adr_q, dat_q, rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= X_IDLE;
            cnt_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                X_IDLE: begin
                    if (req_i) begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= we_i;
                        sel_q   <= 4'hF;
                        adr_q   <= adr_i;
                        dat_q   <= dat_i;
                        cnt_q   <= '0;
                        state_q <= X_ACTIVE;
                    end
                end
                X_ACTIVE: begin
                    // Bus outputs are cleared on ack or timeout so nothing stale lingers between cycles.
                    if (wbm_ack_i || cnt_q == TW'(ACK_TIMEOUT - 1)) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        we_q      <= 1'b0;
                        sel_q     <= '0;
                        adr_q     <= '0;
                        dat_q     <= '0;
                        state_q   <= X_GAP;
                        done_q    <= wbm_ack_i;
                        timeout_q <= !wbm_ack_i;
                        if (wbm_ack_i) begin
                            rdata_q <= wbm_dat_i;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                X_GAP:   state_q <= X_IDLE;
                default: state_q <= X_IDLE;
            endcase
        end
    end

    assign ready_o   = (state_q == X_IDLE);
    assign done_o    = done_q;
    assign timeout_o = timeout_q;
    assign rdata_o   = rdata_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: rtl/sha1_wb_master.sv
// Sequences one SHA1 block through the Wishbone peripheral: ID check, core
// reset, message load, status polling and digest readback.
module sha1_wb_master
    import sha1_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
    parameter int unsigned ACK_TIMEOUT  = 255,
    parameter int unsigned POLL_MAX     = 1023,
    parameter int unsigned POLL_GAP     = 4
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_ni,
    input  logic         start,
    input  logic [511:0] message_i,
    output logic         busy,
    output logic         done,
    output logic [1:0]   err,
    output logic [159:0] digest_o,
    output logic         wbm_cyc_o,
    output logic         wbm_stb_o,
    output logic         wbm_we_o,
    output logic [3:0]   wbm_sel_o,
    output logic [31:0]  wbm_adr_o,
    output logic [31:0]  wbm_dat_o,
    input  logic [31:0]  wbm_dat_i,
    input  logic         wbm_ack_i
);

    localparam int unsigned PW = $clog2(POLL_MAX + 1);
    localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    mst_state_e     state_q;
    err_e           res_q, err_q;
    logic           issued_q, req_q, busy_q, done_q;
    logic [511:0]   msg_q;
    logic [3:0]     widx_q;
    logic [2:0]     didx_q;
    logic [PW-1:0]  poll_q;
    logic [GW-1:0]  gap_q;
    logic [159:0]   dig_buf_q, digest_q;

    logic           bus_state, bus_we;
    logic [31:0]    bus_adr, bus_dat;
    logic           x_ready, x_done, x_to;
    logic [31:0]    x_rdata;

    always_comb begin
        bus_state = 1'b1;
        bus_we    = 1'b0;
        bus_adr   = BASE_ADDRESS + REG_ID_OFF;
        bus_dat   = '0;
        unique case (state_q)
            ST_RD_ID:  bus_adr = BASE_ADDRESS + REG_ID_OFF;
            ST_WR_RST: begin
                bus_we  = 1'b1;
                bus_adr = BASE_ADDRESS + REG_CTRL_OFF;
                bus_dat = ops_mask(OPS_RESET_BIT);
            end
            ST_WR_MSG: begin
                bus_we  = 1'b1;
                bus_adr = BASE_ADDRESS + REG_MSG_OFF;
                bus_dat = msg_q[{widx_q, 5'd0} +: 32];
            end
            ST_POLL:   bus_adr = BASE_ADDRESS + REG_CTRL_OFF;
            ST_RD_DIG: bus_adr = BASE_ADDRESS + REG_DIG_OFF;
            default:   bus_state = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            res_q     <= ERR_OK;
            err_q     <= ERR_OK;
            issued_q  <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            msg_q     <= '0;
            widx_q    <= '0;
            didx_q    <= '0;
            poll_q    <= '0;
            gap_q     <= '0;
            dig_buf_q <= '0;
            digest_q  <= '0;
        end else begin
            done_q <= 1'b0;
            req_q  <= 1'b0;
            if (bus_state && !issued_q && x_ready) begin
                req_q    <= 1'b1;
                issued_q <= 1'b1;
            end
            if (x_done || x_to) begin
                issued_q <= 1'b0;
            end
            if (x_to) begin
                res_q   <= ERR_BUS;
                state_q <= ST_FIN;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            msg_q    <= message_i;
                            busy_q   <= 1'b1;
                            res_q    <= ERR_OK;
                            err_q    <= ERR_OK;
                            widx_q   <= '0;
                            didx_q   <= '0;
                            poll_q   <= '0;
                            issued_q <= 1'b0;
                            state_q  <= ST_RD_ID;
                        end
                    end
                    ST_RD_ID: begin
                        if (x_done) begin
                            if (x_rdata == CTRL_ID) begin
                                state_q <= ST_WR_RST;
                            end else begin
                                res_q   <= ERR_ID;
                                state_q <= ST_FIN;
                            end
                        end
                    end
                    ST_WR_RST: if (x_done) state_q <= ST_WR_MSG;
                    ST_WR_MSG: begin
                        if (x_done) begin
                            if (x_rdata != ACK) begin
                                res_q   <= ERR_BUS;
                                state_q <= ST_FIN;
                            end else if (widx_q == 4'd15) begin
                                state_q <= ST_POLL;
                            end else begin
                                widx_q <= widx_q + 1'b1;
                            end
                        end
                    end
                    ST_POLL: begin
                        if (x_done) begin
                            if (poll_q != PW'(POLL_MAX)) begin
                                poll_q <= poll_q + 1'b1;
                            end
                            if (x_rdata[OPS_DONE_BIT]) begin
                                state_q <= ST_RD_DIG;
                            end else if (poll_q >= PW'(POLL_MAX - 1)) begin
                                res_q   <= ERR_POLL;
                                state_q <= ST_FIN;
                            end else begin
                                gap_q   <= '0;
                                state_q <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (gap_q == GW'(POLL_GAP - 1)) begin
                            state_q <= ST_POLL;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                    ST_RD_DIG: begin
                        // EBUSY leaves the index unchanged so the same word is read again.
                        if (x_done && x_rdata != EBUSY) begin
                            dig_buf_q[{didx_q, 5'd0} +: 32] <= x_rdata;
                            if (didx_q == 3'd4) begin
                                state_q <= ST_FIN;
                            end else begin
                                didx_q <= didx_q + 1'b1;
                            end
                        end
                    end
                    ST_FIN: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        err_q   <= res_q;
                        state_q <= ST_IDLE;
                        if (res_q == ERR_OK) begin
                            digest_q <= dig_buf_q;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    sha1_wbm_xfer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_xfer (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_ni),
        .req_i     (req_q),
        .we_i      (bus_we),
        .adr_i     (bus_adr),
        .dat_i     (bus_dat),
        .ready_o   (x_ready),
        .done_o    (x_done),
        .timeout_o (x_to),
        .rdata_o   (x_rdata),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign digest_o = digest_q;

endmodule

// File: tb/tb_sha1_wb_master.sv
// Bench for sha1_wb_master: behavioural SHA1 slave with fault injection and a
// done-driven scoreboard of expected err/digest results.
module tb_sha1_wb_master;
    import sha1_pkg::*;

    localparam logic [31:0]  BASE    = 32'h30000024;
    localparam logic [159:0] ABC_DIG = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;

    typedef struct {
        logic [1:0]   err;
        logic [159:0] dig;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [511:0] message_i = '0;
    logic         busy, done;
    logic [1:0]   err;
    logic [159:0] digest_o;
    logic         cyc, stb, we, ack;
    logic [3:0]   sel;
    logic [31:0]  adr, wdat, rdat;

    sha1_wb_master #(
        .BASE_ADDRESS(BASE),
        .ACK_TIMEOUT (255),
        .POLL_MAX    (1023),
        .POLL_GAP    (4)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .start    (start),
        .message_i(message_i),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .digest_o (digest_o),
        .wbm_cyc_o(cyc),
        .wbm_stb_o(stb),
        .wbm_we_o (we),
        .wbm_sel_o(sel),
        .wbm_adr_o(adr),
        .wbm_dat_o(wdat),
        .wbm_dat_i(rdat),
        .wbm_ack_i(ack)
    );

    always #5 clk = ~clk;

    // Slave configuration (written only by the stimulus process)
    int          lat = 1;
    logic [31:0] id_val = CTRL_ID;
    logic        no_ack = 1'b0;
    logic        never_done = 1'b0;
    int          einval_at = -1;
    int          ebusy_cfg = 0;
    logic        clr = 1'b0;

    // Slave state and statistics
    int          lat_cnt, ebusy_left, n_ebusy, n_cyc, n_msg, n_poll, run, max_run, idle, min_gap;
    logic [2:0]  dig_idx;
    logic [31:0] rst_val;
    logic [31:0] msg_words [16];
    logic        last_poll, stb_prev;
    logic        poll_now;

    assign poll_now = stb && !we && (adr == BASE + 32'h8);

    function automatic logic [31:0] dig_word(input logic [2:0] k);
        case (k)
            3'd0:    return 32'h9cd0d89d;
            3'd1:    return 32'h7850c26c;
            3'd2:    return 32'hba3e2571;
            3'd3:    return 32'h4706816a;
            3'd4:    return 32'ha9993e36;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n || clr) begin
            ack <= 1'b0; rdat <= '0; lat_cnt <= 0; dig_idx <= '0; ebusy_left <= ebusy_cfg;
            n_ebusy <= 0; n_cyc <= 0; n_msg <= 0; n_poll <= 0; rst_val <= '0; run <= 0;
            max_run <= 0; idle <= 0; min_gap <= 1000000; last_poll <= 1'b0; stb_prev <= 1'b0;
        end else begin
            ack      <= 1'b0;
            stb_prev <= stb;
            run      <= stb ? run + 1 : 0;
            if (stb && run + 1 > max_run) max_run <= run + 1;
            idle <= stb ? 0 : idle + 1;
            if (stb && !stb_prev) begin
                n_cyc <= n_cyc + 1;
                if (poll_now && last_poll && idle < min_gap) min_gap <= idle;
                last_poll <= poll_now;
            end
            if (cyc && stb && !ack && !no_ack) begin
                if (lat_cnt < lat) begin
                    lat_cnt <= lat_cnt + 1;
                end else begin
                    lat_cnt <= 0;
                    ack     <= 1'b1;
                    rdat    <= 32'hbad0bad0;
                    if (adr == BASE + 32'h4 && !we) begin
                        rdat <= id_val;
                    end else if (adr == BASE + 32'h8 && we) begin
                        rst_val <= wdat;
                        rdat    <= ACK;
                    end else if (adr == BASE + 32'h8) begin
                        n_poll <= n_poll + 1;
                        rdat   <= (!never_done && n_poll >= 2) ? 32'h8 : 32'h0;
                    end else if (adr == BASE + 32'hC && we) begin
                        if (n_msg < 16) msg_words[n_msg] <= wdat;
                        n_msg <= n_msg + 1;
                        rdat  <= (n_msg == einval_at) ? EINVAL : ACK;
                    end else if (adr == BASE + 32'h10 && !we) begin
                        if (dig_idx == 3'd2 && ebusy_left > 0) begin
                            rdat       <= EBUSY;
                            ebusy_left <= ebusy_left - 1;
                            n_ebusy    <= n_ebusy + 1;
                        end else begin
                            rdat    <= dig_word(dig_idx);
                            dig_idx <= dig_idx + 1'b1;
                        end
                    end
                end
            end
        end
    end

    int           checks = 0;
    int           failures = 0;
    exp_t         exp_q[$];
    logic [159:0] last_dig;
    logic [511:0] abc_msg;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected actual=done expected=no_done err=%0d", err);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_err", err, e.err);
                    chk("done_digest", digest_o, e.dig);
                    chk("busy_at_done", busy, 0);
                end
            end
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic run_op(input logic [511:0] msg, input logic [1:0] e_err, input logic [159:0] e_dig);
        exp_t e;
        @(negedge clk);
        message_i = msg;
        start     = 1'b1;
        e.err     = e_err;
        e.dig     = e_dig;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_ops(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done expected=done_within_%0d", name, budget);
            exp_q.delete();
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        fork
            monitor();
        join_none

        abc_msg = '0;
        abc_msg[31:0]    = 32'h00000018;
        abc_msg[511:480] = 32'h61626380;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_digest", digest_o, 0);
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_we", we, 0);
        chk("rst_sel", sel, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", wdat, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_bus_after_reset", n_cyc, 0);
        last_dig = '0;

        // abc block, EBUSY retries, start while busy ignored
        lat = 2; ebusy_cfg = 2;
        pulse_clr();
        run_op(abc_msg, ERR_OK, ABC_DIG);
        repeat (30) @(negedge clk);
        message_i = {16{32'hA5A5A5A5}};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ops("abc", 4000);
        last_dig = ABC_DIG;
        chk("abc_msg_writes", n_msg, 16);
        for (int k = 0; k < 16; k++) chk($sformatf("abc_msg_word%0d", k), msg_words[k], abc_msg[k*32 +: 32]);
        chk("abc_rst_write", rst_val, 32'h2);
        chk("abc_ebusy_served", n_ebusy, 2);
        chk("abc_polls", n_poll, 3);
        ebusy_cfg = 0;

        // Bad ID
        lat = 0; id_val = 32'hdeadbeef;
        pulse_clr();
        run_op(abc_msg, ERR_ID, last_dig);
        wait_ops("bad_id", 500);
        chk("bad_id_bus_cycles", n_cyc, 1);
        id_val = CTRL_ID;

        // No ack
        no_ack = 1'b1;
        pulse_clr();
        run_op(abc_msg, ERR_BUS, last_dig);
        wait_ops("no_ack", 1000);
        chk("no_ack_stb_run", max_run, 255);
        chk("no_ack_bus_cycles", n_cyc, 1);
        no_ack = 1'b0;

        // EINVAL on message word 5
        einval_at = 5;
        pulse_clr();
        run_op(abc_msg, ERR_BUS, last_dig);
        wait_ops("einval", 2000);
        chk("einval_msg_writes", n_msg, 6);
        einval_at = -1;

        // DONE never set
        never_done = 1'b1;
        pulse_clr();
        run_op(abc_msg, ERR_POLL, last_dig);
        wait_ops("poll_timeout", 30000);
        chk("poll_count", n_poll, 1023);
        chk("poll_gap_at_least_4", (min_gap >= 4), 1);
        never_done = 1'b0;

        // Reset during message word 7, then a clean run
        pulse_clr();
        @(negedge clk);
        message_i = abc_msg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(stb && we && adr == BASE + 32'hC && n_msg == 7) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_msg_word7", (stb && we && adr == BASE + 32'hC && n_msg == 7), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_cyc", cyc, 0);
        chk("midrst_stb", stb, 0);
        chk("midrst_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_no_bus", n_cyc, 0);
        chk("midrst_digest_cleared", digest_o, 0);
        last_dig = '0;
        run_op(abc_msg, ERR_OK, ABC_DIG);
        wait_ops("after_reset", 4000);
        chk("after_reset_msg_writes", n_msg, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
